// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with extra-bit pointers, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and optional FWFT read port.
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL = AE_THRESH[AW:0];

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_flags: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_af
        $error("fifo_sync_flags: AF_THRESH must be in 1..FIFO_DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_flags: AE_THRESH must be in 0..FIFO_DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("fifo_sync_flags: FWFT must be 0 or 1");
    end

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  wr_accept;
    logic                  rd_accept;
    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Flags come straight from the registered pointers; the wrap bit separates full from empty.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_accept = cs && wr_en && !full;
    assign rd_accept = cs && rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Errors are sticky; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (cs && wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (cs && rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Drive zero while empty so the port shows 0 after reset instead of stale memory.
        assign data_out = empty ? '0 : mem[rd_idx];
        assign rd_valid = !empty;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) begin
                    data_q <= mem[rd_idx];
                end
            end
        end

        assign data_out = data_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags: registered-read instance plus an FWFT instance,
// both compared against a queue-based reference model.
module tb_fifo_sync_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, cs, wr_en, rd_en, clr_err;
    logic [DW-1:0] data_in, data_out;
    logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [CW-1:0] count;

    logic          f_rst, f_cs, f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_data_in, f_data_out;
    logic          f_rd_valid, f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [CW-1:0] f_count;

    int checks = 0;
    int errors = 0;

    // Reference model for the registered-read instance.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rdv, m_ovf, m_udf;

    // Reference model for the FWFT instance.
    logic [DW-1:0] fq[$];

    always #5 clk = ~clk;

    fifo_sync_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT),
                      .AE_THRESH(AET), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    fifo_sync_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT),
                      .AE_THRESH(AET), .FWFT(1)) dut_f (
        .clk(clk), .rst(f_rst), .cs(f_cs), .wr_en(f_wr_en), .rd_en(f_rd_en),
        .data_in(f_data_in), .data_out(f_data_out), .rd_valid(f_rd_valid),
        .empty(f_empty), .full(f_full), .almost_empty(f_almost_empty),
        .almost_full(f_almost_full), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .clr_err(f_clr_err)
    );

    // Drive one cycle on the registered instance and advance the model; outputs settle #1 after the edge.
    task automatic step(input logic r, input logic c, input logic w, input logic rd,
                        input logic [DW-1:0] d, input logic clr);
        logic was_full, was_empty;
        rst = r; cs = c; wr_en = w; rd_en = rd; data_in = d; clr_err = clr;
        @(posedge clk);
        #1;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_rdv = 1'b0;
        if (r) begin
            q.delete();
            m_dout = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (c && rd && !was_empty) begin
                m_dout = q.pop_front();
                m_rdv = 1'b1;
            end
            if (c && w && !was_full) q.push_back(d);
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (c && w && was_full) m_ovf = 1'b1;
            if (c && rd && was_empty) m_udf = 1'b1;
        end
        rst = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic f_step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic was_full, was_empty;
        f_rst = r; f_cs = 1'b1; f_wr_en = w; f_rd_en = rd; f_data_in = d; f_clr_err = 1'b0;
        @(posedge clk);
        #1;
        was_full  = (fq.size() == DEPTH);
        was_empty = (fq.size() == 0);
        if (r) begin
            fq.delete();
        end else begin
            if (rd && !was_empty) void'(fq.pop_front());
            if (w && !was_full) fq.push_back(d);
        end
        f_rst = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        f_rst = 1'b1; f_cs = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_data_in = '0;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        f_rst = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_empty_full: got %b%b expected 10", empty, full); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0", almost_empty, almost_full); end
        checks++; if (data_out !== '0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout: got %h/%b expected 0/0", data_out, rd_valid); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b%b expected 00", overflow, underflow); end
        checks++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_data_out !== '0) begin errors++; $display("[TB] FAIL reset_fwft: got empty=%b valid=%b dout=%h expected 1 0 0", f_empty, f_rd_valid, f_data_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, DW'(32'h11 * i), 1'b0);
            checks++; if (count !== CW'(i)) begin errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, i); end
            checks++; if (almost_full !== (i >= AFT)) begin errors++; $display("[TB] FAIL fill_af: got %b expected %b at count %0d", almost_full, (i >= AFT), i); end
            checks++; if (full !== (i == DEPTH)) begin errors++; $display("[TB] FAIL fill_full: got %b expected %b at count %0d", full, (i == DEPTH), i); end
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h99, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow: got %b expected 1", overflow); end
        checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin errors++; $display("[TB] FAIL fill_reject: got count=%0d full=%b expected %0d 1", count, full, DEPTH); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
            checks++; if (data_out !== DW'(32'h11 * i)) begin errors++; $display("[TB] FAIL drain_data: got %h expected %h", data_out, DW'(32'h11 * i)); end
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid: got %b expected 1", rd_valid); end
            checks++; if (almost_empty !== ((DEPTH - i) <= AET)) begin errors++; $display("[TB] FAIL drain_ae: got %b expected %b at count %0d", almost_empty, ((DEPTH - i) <= AET), DEPTH - i); end
            checks++; if (empty !== (i == DEPTH) || count !== CW'(DEPTH - i)) begin errors++; $display("[TB] FAIL drain_level: got empty=%b count=%0d expected %b %0d", empty, count, (i == DEPTH), DEPTH - i); end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL drain_underflow: got %b expected 1", underflow); end
        checks++; if (rd_valid !== 1'b0 || data_out !== DW'(32'h88)) begin errors++; $display("[TB] FAIL drain_hold: got %h/%b expected 88/0", data_out, rd_valid); end
    endtask

    task automatic test_clr_err();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_err: got %b%b expected 00", overflow, underflow); end
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_err_idle: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, DW'($urandom), 1'b0);
            checks++; if (count !== CW'(3)) begin errors++; $display("[TB] FAIL steady_count: got %0d expected 3", count); end
            checks++; if (data_out !== m_dout || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL steady_data: got %h/%b expected %h/1", data_out, rd_valid, m_dout); end
        end
    endtask

    task automatic test_full_simul();
        while (q.size() < DEPTH) step(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fs_full: got %b expected 1", full); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checks++; if (data_out !== m_dout) begin errors++; $display("[TB] FAIL fs_oldest: got %h expected %h", data_out, m_dout); end
        checks++; if (overflow !== 1'b1 || count !== CW'(DEPTH - 1)) begin errors++; $display("[TB] FAIL fs_drop: got ovf=%b count=%0d expected 1 %0d", overflow, count, DEPTH - 1); end
        while (q.size() > 0) step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
        checks++; if (underflow !== 1'b1 || count !== CW'(1)) begin errors++; $display("[TB] FAIL es_write: got udf=%b count=%0d expected 1 1", underflow, count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL es_no_read: got %b expected 0", rd_valid); end
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b1);
        checks++; if (data_out !== 32'hCAFE_0001 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL es_stored: got %h udf=%b expected cafe0001 0", data_out, underflow); end
    endtask

    task automatic test_cs_gate();
        while (q.size() < DEPTH) step(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        checks++; if (count !== CW'(DEPTH) || overflow !== 1'b0) begin errors++; $display("[TB] FAIL cs_full: got count=%0d ovf=%b expected %0d 0", count, overflow, DEPTH); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL cs_read: got %b expected 0", rd_valid); end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL cs_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b0);
        checks++; if (count !== CW'(5)) begin errors++; $display("[TB] FAIL mr_pre: got %0d expected 5", count); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checks++; if (count !== '0 || empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL mr_level: got count=%0d empty=%b ae=%b expected 0 1 1", count, empty, almost_empty); end
        checks++; if (data_out !== '0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_dout: got %h/%b expected 0/0", data_out, rd_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 DW'($urandom), ($urandom_range(0, 15) == 0));
            checks++; if (count !== CW'(q.size())) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", count, q.size()); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_ef: got %b%b size %0d", empty, full, q.size()); end
            checks++; if (almost_empty !== (q.size() <= AET) || almost_full !== (q.size() >= AFT)) begin errors++; $display("[TB] FAIL rnd_almost: got ae=%b af=%b size %0d", almost_empty, almost_full, q.size()); end
            checks++; if (data_out !== m_dout || rd_valid !== m_rdv) begin errors++; $display("[TB] FAIL rnd_data: got %h/%b expected %h/%b", data_out, rd_valid, m_dout, m_rdv); end
            checks++; if (overflow !== m_ovf || underflow !== m_udf) begin errors++; $display("[TB] FAIL rnd_err: got %b%b expected %b%b", overflow, underflow, m_ovf, m_udf); end
        end
    endtask

    task automatic test_fwft();
        f_step(1'b1, 1'b0, 1'b0, '0);
        f_step(1'b0, 1'b1, 1'b0, 32'hA5);
        checks++; if (f_data_out !== 32'hA5 || f_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL fwft_show: got %h/%b expected a5/1", f_data_out, f_rd_valid); end
        f_step(1'b0, 1'b0, 1'b1, '0);
        checks++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fwft_pop: got empty=%b valid=%b expected 1 0", f_empty, f_rd_valid); end
        for (int i = 0; i < 100; i++) begin
            f_step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, DW'($urandom));
            checks++; if (f_rd_valid !== (fq.size() != 0) || f_count !== CW'(fq.size())) begin errors++; $display("[TB] FAIL fwft_level: got valid=%b count=%0d expected size %0d", f_rd_valid, f_count, fq.size()); end
            if (fq.size() != 0) begin
                checks++; if (f_data_out !== fq[0]) begin errors++; $display("[TB] FAIL fwft_head: got %h expected %h", f_data_out, fq[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
        m_dout = '0; m_rdv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_clr_err();
        test_steady();
        test_full_simul();
        test_cs_gate();
        test_mid_reset();
        test_random();
        test_fwft();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
